prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the pipeline's external memory write port.
- Accepts a byte stream (valid/ready), assembles little-endian 32-bit words and writes them into data/instruction memory through Ext_MemWrite / Ext_WriteData / Ext_DataAdr.
- Holds the pipeline in reset via cpu_reset while loading; releases the core once the final word is written.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 1024, largest legal word count N.
- TIMEOUT, 100000, idle cycles allowed between accepted bytes in LEN/DATA; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin (or restart) a load; single-cycle pulse or level
- in_valid  in  1  byte available
- in_data  in  8  byte value
- in_ready  out  1  loader accepts a byte this cycle
- Ext_MemWrite  out  1  one-cycle memory write strobe, to the pipeline
- Ext_WriteData  out  32  word to write
- Ext_DataAdr  out  32  byte address of the write
- cpu_reset  out  1  drives the pipeline's reset; 1 = core held
- load_done  out  1  load completed successfully
- load_error  out  1  load aborted (bad length or timeout)

Behaviour:
- All outputs are registered. One clock, asynchronous active-high reset.
- Reset values: state IDLE, cpu_reset=1, Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=BASE_ADDR, in_ready=0, load_done=0, load_error=0. Byte counter, word index and timeout counter are 0.
- Byte transfer: occurs on a rising edge with in_valid && in_ready.
- Byte packing: byte k (k=0..3) of a word goes to bits [8k+7:8k], little-endian.
- IDLE: cpu_reset=1, in_ready=0. On start go to LEN with in_ready=1.
- LEN: receive 4 bytes forming N.
  - After the 4th byte: N==0 or N>MAX_WORDS -> ERROR; otherwise -> DATA.
  - Word index = 0.
- DATA: receive 4 bytes. After the 4th byte -> WRITE, with in_ready=0 from the next cycle.
- WRITE: lasts exactly 1 cycle.
  - Ext_MemWrite=1.
  - Ext_WriteData = assembled word.
  - Ext_DataAdr = BASE_ADDR + 4*index, computed modulo 2^32.
  - Then index++. If index==N -> DONE, else -> DATA (in_ready=1).
- Write latency: Ext_MemWrite is high in the cycle immediately after the edge that accepted the 4th byte. Minimum 5 cycles per word.
- Address and data hold: Ext_DataAdr and Ext_WriteData keep their last value outside WRITE. Ext_MemWrite=0 outside WRITE.
- DONE:
  - cpu_reset=0 and load_done=1, both starting in the first cycle in DONE.
  - Ext_MemWrite=0 in that same cycle, so the last write never overlaps core release.
  - in_ready=0.
- ERROR: cpu_reset stays 1, load_error=1, in_ready=0. Memory writes already issued are not undone.
- start handling:
  - start in DONE or ERROR -> LEN on the next cycle: cpu_reset=1 from that cycle, load_done/load_error cleared, counters cleared.
  - start in LEN, DATA or WRITE is ignored.
- Timeout:
  - In LEN/DATA with TIMEOUT!=0, the counter increments each cycle without a transfer and clears on each transfer.
  - Reaching TIMEOUT -> ERROR.
  - Counter is cleared on entry to LEN and DATA.
- in_valid while in_ready=0: the byte is not consumed. The source must hold it.
- Reset mid-load: everything returns immediately to reset values. The partial word is discarded and cpu_reset=1.
- N=MAX_WORDS is legal. The final address is BASE_ADDR+4*(MAX_WORDS-1).

Test Plan:
- Normal load:
  - Stimulus: reset, start, bytes 02 00 00 00, 13 05 50 00, 93 05 a0 00, in_valid continuously high.
  - Response: writes 0x00500513 @0x0 then 0x00a00593 @0x4, each exactly 1 cycle long and each 1 cycle after the 4th byte. Then cpu_reset=0, load_done=1.
- Bad length:
  - Stimulus: start, length bytes 00 00 00 00. Separately, length 0x00000401 with MAX_WORDS=1024.
  - Response: in both cases load_error=1, cpu_reset stays 1, no Ext_MemWrite pulse.
- Timeout and gaps:
  - Stimulus: TIMEOUT=8, N=1; send 2 data bytes, then in_valid=0 for 8 cycles.
  - Response: ERROR, load_error=1. Separately, random valid gaps shorter than 8 cycles must still complete correctly.
- Reset mid-load:
  - Stimulus: assert reset after the 2nd data byte of word 0.
  - Response: outputs immediately return to reset values; no write issued. A subsequent full load of N=1 writes the correct word @BASE_ADDR.
- Reload:
  - Stimulus: after DONE, pulse start and load N=1 word 0xDEADBEEF.
  - Response: cpu_reset=1 the cycle after start, load_done cleared, write 0xDEADBEEF @BASE_ADDR, then DONE again.
- Ignored start / backpressure:
  - Stimulus: pulse start during DATA and during WRITE.
  - Response: no state change. in_ready=0 during WRITE; a byte offered then is taken in the following DATA cycle.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit words,
// writes them through the external memory port and holds the core in reset until done.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [31:0] LP_MAX_WORDS = 32'(MAX_WORDS);
  localparam logic [31:0] LP_TIMEOUT   = 32'(TIMEOUT);
  localparam bit          LP_TMO_EN    = (TIMEOUT != 0);

  state_t      r_state, w_state;
  logic [1:0]  r_bcnt, w_bcnt;
  logic [23:0] r_shift, w_shift;
  logic [31:0] r_len, w_len;
  logic [31:0] r_idx, w_idx;
  logic [31:0] r_tmo, w_tmo;
  logic        r_in_ready, w_in_ready;
  logic        r_mem_write, w_mem_write;
  logic [31:0] r_wdata, w_wdata;
  logic [31:0] r_addr, w_addr;
  logic        r_cpu_reset, w_cpu_reset;
  logic        r_done, w_done;
  logic        r_error, w_error;

  logic        w_xfer;
  logic [31:0] w_word;
  logic        w_len_bad;
  logic        w_tmo_hit;
  logic [31:0] w_idx_inc;

  // The incoming byte completes the word as its most significant byte.
  assign w_xfer    = in_valid && r_in_ready;
  assign w_word    = {in_data, r_shift};
  assign w_len_bad = (w_word == 32'd0) || (w_word > LP_MAX_WORDS);
  assign w_tmo_hit = LP_TMO_EN && !w_xfer && (r_tmo == (LP_TIMEOUT - 32'd1));
  assign w_idx_inc = r_idx + 32'd1;

  // Next-state and next-output computation for every loader register
  always_comb begin
    w_state     = r_state;
    w_bcnt      = r_bcnt;
    w_shift     = r_shift;
    w_len       = r_len;
    w_idx       = r_idx;
    w_tmo       = r_tmo;
    w_in_ready  = r_in_ready;
    w_mem_write = 1'b0;
    w_wdata     = r_wdata;
    w_addr      = r_addr;
    w_cpu_reset = r_cpu_reset;
    w_done      = r_done;
    w_error     = r_error;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state     = S_LEN;
          w_in_ready  = 1'b1;
          w_cpu_reset = 1'b1;
          w_done      = 1'b0;
          w_error     = 1'b0;
          w_bcnt      = 2'd0;
          w_idx       = 32'd0;
          w_tmo       = 32'd0;
        end else begin
          w_in_ready  = 1'b0;
        end
      end
      S_LEN, S_DATA: begin
        if (w_xfer) begin
          w_tmo = 32'd0;
          if (r_bcnt == 2'd3) begin
            w_bcnt = 2'd0;
            if (r_state == S_LEN) begin
              w_len = w_word;
              w_idx = 32'd0;
              if (w_len_bad) begin
                w_state    = S_ERROR;
                w_in_ready = 1'b0;
                w_error    = 1'b1;
              end else begin
                w_state    = S_DATA;
              end
            end else begin
              // Word complete: the write strobe appears in the very next cycle.
              w_state     = S_WRITE;
              w_in_ready  = 1'b0;
              w_mem_write = 1'b1;
              w_wdata     = w_word;
              w_addr      = BASE_ADDR + {r_idx[29:0], 2'b00};
            end
          end else begin
            w_bcnt  = r_bcnt + 2'd1;
            w_shift = w_word[31:8];
          end
        end else if (w_tmo_hit) begin
          w_state    = S_ERROR;
          w_in_ready = 1'b0;
          w_error    = 1'b1;
        end else if (LP_TMO_EN) begin
          w_tmo = r_tmo + 32'd1;
        end else begin
          w_tmo = r_tmo;
        end
      end
      S_WRITE: begin
        w_idx = w_idx_inc;
        if (w_idx_inc == r_len) begin
          w_state     = S_DONE;
          w_in_ready  = 1'b0;
          w_cpu_reset = 1'b0;
          w_done      = 1'b1;
        end else begin
          w_state    = S_DATA;
          w_in_ready = 1'b1;
          w_tmo      = 32'd0;
        end
      end
      default: begin
        w_state    = S_IDLE;
        w_in_ready = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bcnt      <= 2'd0;
      r_shift     <= 24'd0;
      r_len       <= 32'd0;
      r_idx       <= 32'd0;
      r_tmo       <= 32'd0;
      r_in_ready  <= 1'b0;
      r_mem_write <= 1'b0;
      r_wdata     <= 32'd0;
      r_addr      <= BASE_ADDR;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bcnt      <= w_bcnt;
      r_shift     <= w_shift;
      r_len       <= w_len;
      r_idx       <= w_idx;
      r_tmo       <= w_tmo;
      r_in_ready  <= w_in_ready;
      r_mem_write <= w_mem_write;
      r_wdata     <= w_wdata;
      r_addr      <= w_addr;
      r_cpu_reset <= w_cpu_reset;
      r_done      <= w_done;
      r_error     <= w_error;
    end
  end

  assign in_ready      = r_in_ready;
  assign Ext_MemWrite  = r_mem_write;
  assign Ext_WriteData = r_wdata;
  assign Ext_DataAdr   = r_addr;
  assign cpu_reset     = r_cpu_reset;
  assign load_done     = r_done;
  assign load_error    = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: expected writes are queued by the driver
// from the load rules and popped by a monitor whenever Ext_MemWrite is seen.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 1024;
  localparam int unsigned TMO  = 8;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, Ext_MemWrite, cpu_reset, load_done, load_error;
  logic [31:0] Ext_WriteData, Ext_DataAdr;

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .Ext_MemWrite(Ext_MemWrite), .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr(Ext_DataAdr), .cpu_reset(cpu_reset), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned stamp;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] wq[$];
  int unsigned last_wr_cyc = 0;
  logic [31:0] last_exp_addr = BASE;
  logic [31:0] last_exp_data = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: each write strobe consumes one expected write
  always @(negedge clk) begin
    if (!reset && Ext_MemWrite) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", Ext_DataAdr, Ext_WriteData);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", Ext_DataAdr, mon_e.addr);
        check("wr_data", Ext_WriteData, mon_e.data);
        check("wr_latency", cyc, mon_e.stamp);
        check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
        check("cpu_held_in_write", {31'd0, cpu_reset}, 32'd1);
      end
      last_wr_cyc = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke, output int unsigned edge_no);
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start = poke && ($urandom_range(1, 0) == 1);
    end
    edge_no = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = b;
      start = poke && ($urandom_range(1, 0) == 1);
      if (in_ready) begin
        edge_no = cyc + 1;
        break;
      end
    end
    if (edge_no == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept: in_ready stayed 0, expected 1 within 40 cycles");
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax, input bit poke, output int unsigned edge_no);
    int g;
    for (int k = 0; k < 4; k++) begin
      g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      send_byte(w[8*k +: 8], g, poke, edge_no);
    end
  endtask

  // Full load: words come from wq, then random; only a legal length is followed by data
  task automatic load(input logic [31:0] n_len, input int gmax, input bit poke);
    int unsigned e;
    int unsigned nwords;
    logic [31:0] w;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", {31'd0, in_ready}, 32'd1);
    check("start_cpu_held", {31'd0, cpu_reset}, 32'd1);
    check("start_done_clr", {31'd0, load_done}, 32'd0);
    check("start_err_clr", {31'd0, load_error}, 32'd0);
    send_word(n_len, gmax, poke, e);
    nwords = (n_len != 32'd0 && n_len <= MAXW) ? n_len : 0;
    for (int unsigned i = 0; i < nwords; i++) begin
      w = (i < wq.size()) ? wq[i] : $urandom;
      send_word(w, gmax, poke, e);
      last_exp_addr = BASE + 32'(4 * i);
      last_exp_data = w;
      exp_q.push_back('{last_exp_addr, w, e});
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_end(input bit exp_done, input string tag);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (load_done || load_error) break;
    end
    check({tag, "_done"}, {31'd0, load_done}, {31'd0, exp_done});
    check({tag, "_error"}, {31'd0, load_error}, {31'd0, !exp_done});
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !exp_done});
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    if (exp_done) begin
      check({tag, "_done_latency"}, cyc, last_wr_cyc + 1);
      check({tag, "_hold_addr"}, Ext_DataAdr, last_exp_addr);
      check({tag, "_hold_data"}, Ext_WriteData, last_exp_data);
      check({tag, "_no_write"}, {31'd0, Ext_MemWrite}, 32'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_memwrite"}, {31'd0, Ext_MemWrite}, 32'd0);
    check({tag, "_wdata"}, Ext_WriteData, 32'd0);
    check({tag, "_addr"}, Ext_DataAdr, BASE);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_error"}, {31'd0, load_error}, 32'd0);
  endtask

  initial begin
    int unsigned e;
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #2;
    check_reset_vals("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // IDLE ignores offered bytes without start
    in_valid = 1'b1;
    in_data = 8'h5a;
    repeat (3) @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Directed normal load
    wq.delete();
    wq.push_back(32'h0050_0513);
    wq.push_back(32'h00a0_0593);
    load(32'd2, 0, 1'b0);
    wait_end(1'b1, "normal");

    // Reload from DONE
    wq.delete();
    wq.push_back(32'hDEAD_BEEF);
    load(32'd1, 0, 1'b0);
    wait_end(1'b1, "reload");

    // Bad lengths
    wq.delete();
    load(32'd0, 0, 1'b0);
    wait_end(1'b0, "len_zero");
    load(32'h0000_0401, 0, 1'b0);
    wait_end(1'b0, "len_big");

    // Timeout after two data bytes of N=1
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'd1, 0, 1'b0, e);
    send_byte(8'h11, 0, 1'b0, e);
    send_byte(8'h22, 0, 1'b0, e);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (i == 8) check("tmo_not_early", {31'd0, load_error}, 32'd0);
    end
    @(negedge clk);
    check("tmo_error", {31'd0, load_error}, 32'd1);
    check("tmo_cpu_held", {31'd0, cpu_reset}, 32'd1);
    check("tmo_ready", {31'd0, in_ready}, 32'd0);

    // Reset in the middle of word 0
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_word(32'd1, 0, 1'b0, e);
    send_byte(8'h33, 0, 1'b0, e);
    send_byte(8'h44, 0, 1'b0, e);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    wq.delete();
    wq.push_back(32'hCAFE_F00D);
    load(32'd1, 0, 1'b0);
    wait_end(1'b1, "after_rst");

    // Random loads with short gaps and ignored start pulses
    wq.delete();
    for (int r = 0; r < 8; r++) begin
      load(32'($urandom_range(5, 1)), 6, 1'b1);
      wait_end(1'b1, "rand");
    end

    // Largest legal length
    load(32'(MAXW), 0, 1'b0);
    wait_end(1'b1, "maxw");
    check("maxw_final_addr", Ext_DataAdr, BASE + 32'(4 * (MAXW - 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
